editor_campos_rtc: RTL

Field-edit controller for the RTC date/time setting path. It holds the six editable fields, selects the active one with left/right pulses, and drives the external increment/decrement wrap unit (`dato_ent`, `max`, `s_r`), writing its `dato_sal` back into the selected field. It also keeps the day-of-month valid after month or year edits, and emits a one-cycle commit strobe toward the RTC write sequencer when edit mode ends.

---
 rtl/rtc_edicion_pkg.sv | 26 ++
 rtl/editor_campos_rtc_dias_del_mes.sv | 33 +++
 rtl/editor_campos_rtc.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/rtc_edicion_pkg.sv
// Shared definitions for the RTC field editor: FSM states, field indices
// and the fixed wrap limits of the editable fields.
package rtc_edicion_pkg;

  typedef enum logic [2:0] {
    REPOSO   = 3'd0,
    EDICION  = 3'd1,
    CALCULO  = 3'd2,
    AJUSTE   = 3'd3,
    CONFIRMA = 3'd4
  } estado_t;

  localparam logic [2:0] CAMPO_SEG  = 3'd0;
  localparam logic [2:0] CAMPO_MIN  = 3'd1;
  localparam logic [2:0] CAMPO_HORA = 3'd2;
  localparam logic [2:0] CAMPO_DIA  = 3'd3;
  localparam logic [2:0] CAMPO_MES  = 3'd4;
  localparam logic [2:0] CAMPO_ANIO = 3'd5;

  localparam int LIM_SEG  = 59;
  localparam int LIM_MIN  = 59;
  localparam int LIM_HORA = 23;
  localparam int LIM_ANIO = 99;
  localparam int LIM_MES  = 12;

endpackage

// File: rtl/editor_campos_rtc_dias_del_mes.sv
// Day count of a month. February gets 29 days in years whose two low bits
// are zero only when EDITOR_BISIESTO_EN is defined; otherwise it has 28.
module dias_del_mes #(
  parameter int ANCHO = 7
) (
  input  logic [ANCHO-1:0] mes,
  input  logic [ANCHO-1:0] anio,
  output logic [ANCHO-1:0] dias
);

`ifdef EDITOR_BISIESTO_EN
  localparam bit BISIESTO = 1'b1;
`else
  localparam bit BISIESTO = 1'b0;
`endif

  logic anio_mult4;
  assign anio_mult4 = ((anio & ANCHO'(3)) == '0);

  // Month-to-length lookup
  always_comb begin
    dias = ANCHO'(31);
    case (mes)
      ANCHO'(2):  dias = (BISIESTO && anio_mult4) ? ANCHO'(29) : ANCHO'(28);
      ANCHO'(4),
      ANCHO'(6),
      ANCHO'(9),
      ANCHO'(11): dias = ANCHO'(30);
      default:    dias = ANCHO'(31);
    endcase
  end

endmodule

// File: rtl/editor_campos_rtc.sv
// RTC date/time field editor: field selection, wrap-unit operand mux,
// day-of-month clamp after month/year edits and the commit strobe.
// Leap-year February is enabled by defining EDITOR_BISIESTO_EN.
module editor_campos_rtc
  import rtc_edicion_pkg::*;
#(
  parameter int ANCHO = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_edicion,
  input  logic             btn_arriba,
  input  logic             btn_abajo,
  input  logic             btn_izq,
  input  logic             btn_der,
  input  logic             cargar,
  input  logic [ANCHO-1:0] ini_seg,
  input  logic [ANCHO-1:0] ini_min,
  input  logic [ANCHO-1:0] ini_hora,
  input  logic [ANCHO-1:0] ini_dia,
  input  logic [ANCHO-1:0] ini_mes,
  input  logic [ANCHO-1:0] ini_anio,
  input  logic [ANCHO-1:0] dato_sal,
  output logic [ANCHO-1:0] dato_ent,
  output logic [ANCHO-1:0] max,
  output logic             s_r,
  output logic [ANCHO-1:0] seg,
  output logic [ANCHO-1:0] min,
  output logic [ANCHO-1:0] hora,
  output logic [ANCHO-1:0] dia,
  output logic [ANCHO-1:0] mes,
  output logic [ANCHO-1:0] anio,
  output logic [2:0]       campo_sel,
  output logic             escribir,
  output logic             ocupado
);

  localparam logic [ANCHO-1:0] UNO = ANCHO'(1);

  estado_t          estado;
  logic [ANCHO-1:0] dias_mes;
  logic [ANCHO-1:0] valor_sel;
  logic [ANCHO-1:0] limite;
  logic             base1;
  logic [ANCHO-1:0] resultado;

  dias_del_mes #(.ANCHO(ANCHO)) u_dias (
    .mes  (mes),
    .anio (anio),
    .dias (dias_mes)
  );

  // Select the active field and its inclusive upper limit
  always_comb begin
    valor_sel = seg;
    limite    = ANCHO'(LIM_SEG);
    base1     = 1'b0;
    case (campo_sel)
      CAMPO_MIN:  begin valor_sel = min;  limite = ANCHO'(LIM_MIN); end
      CAMPO_HORA: begin valor_sel = hora; limite = ANCHO'(LIM_HORA); end
      CAMPO_DIA:  begin valor_sel = dia;  limite = dias_mes; base1 = 1'b1; end
      CAMPO_MES:  begin valor_sel = mes;  limite = ANCHO'(LIM_MES); base1 = 1'b1; end
      CAMPO_ANIO: begin valor_sel = anio; limite = ANCHO'(LIM_ANIO); end
      default:    ;
    endcase
  end

  // The wrap unit counts from zero, so 1-based fields are shifted down on
  // the way out and back up on the way in.
  assign dato_ent  = base1 ? valor_sel - UNO : valor_sel;
  assign max       = base1 ? limite - UNO    : limite;
  assign resultado = base1 ? dato_sal + UNO  : dato_sal;
  assign ocupado   = (estado == CALCULO) || (estado == AJUSTE) || (estado == CONFIRMA);

  // Edit FSM with the field registers and registered control outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado    <= REPOSO;
      seg       <= '0;
      min       <= '0;
      hora      <= '0;
      dia       <= UNO;
      mes       <= UNO;
      anio      <= '0;
      campo_sel <= CAMPO_SEG;
      s_r       <= 1'b0;
      escribir  <= 1'b0;
    end else begin
      escribir <= 1'b0;
      case (estado)
        REPOSO: begin
          if (cargar) begin
            seg  <= ini_seg;
            min  <= ini_min;
            hora <= ini_hora;
            dia  <= ini_dia;
            mes  <= ini_mes;
            anio <= ini_anio;
          end
          if (en_edicion) begin
            estado    <= EDICION;
            campo_sel <= CAMPO_SEG;
          end
        end
        EDICION: begin
          if (!en_edicion) begin
            estado   <= CONFIRMA;
            escribir <= 1'b1;
          end else if (btn_arriba ^ btn_abajo) begin
            s_r    <= btn_arriba;
            estado <= CALCULO;
          end else if (btn_arriba & btn_abajo) begin
            // Contradictory request: take no action this cycle
          end else if (btn_der) begin
            campo_sel <= (campo_sel == CAMPO_ANIO) ? CAMPO_SEG : campo_sel + 3'd1;
          end else if (btn_izq) begin
            campo_sel <= (campo_sel == CAMPO_SEG) ? CAMPO_ANIO : campo_sel - 3'd1;
          end
        end
        CALCULO: begin
          case (campo_sel)
            CAMPO_SEG:  seg  <= resultado;
            CAMPO_MIN:  min  <= resultado;
            CAMPO_HORA: hora <= resultado;
            CAMPO_DIA:  dia  <= resultado;
            CAMPO_MES:  mes  <= resultado;
            CAMPO_ANIO: anio <= resultado;
            default:    ;
          endcase
          estado <= ((campo_sel == CAMPO_MES) || (campo_sel == CAMPO_ANIO)) ? AJUSTE : EDICION;
        end
        AJUSTE: begin
          if (dia > dias_mes) dia <= dias_mes;
          estado <= EDICION;
        end
        CONFIRMA: estado <= REPOSO;
        default:  estado <= REPOSO;
      endcase
    end
  end

endmodule
